sdram_pattern_tester: RTL and testbench

//  Parametrised SDRAM self-test master; drives sdram_ctrl through its req/ack user port.

---
 rtl/sdram_pattern_tester.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// Self-test master for sdram_ctrl: writes a pattern over a window of words through the
// req/ack user port, reads it back, and reports mismatches, timeouts and passing passes.
`timescale 1ns/1ps
module sdram_pattern_tester #(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 24,
  parameter int          INIT_WAIT  = 25000,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned WORD_COUNT = 256,
  parameter int unsigned SEED       = 'hF055,
  parameter int          TIMEOUT    = 1023,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop_en,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rh_wl,
  output logic [DATA_W-1:0] sdram_data_w,
  input  logic [DATA_W-1:0] sdram_data_r,
  input  logic              sdram_data_r_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        pass_cnt,
  output logic [7:0]        led
);

  localparam int INIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WORD_COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(START_ADDR);
  localparam logic [DATA_W-1:0] SEED_W    = DATA_W'(SEED);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
  } state_t;

  state_t state, state_next;

  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        mode_q;
  logic              ack_seen;
  logic [DATA_W-1:0] pattern;
  logic              last_word;
  logic              wait_expired;
  logic              rd_ack;
  logic              rd_hit;
  logic              mismatch;
  logic              start_pass;
  logic              word_done;
  logic              abort;
  logic              finish;

  assign word_addr    = BASE_ADDR + idx;
  assign last_word    = (idx == LAST_IDX);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  // Read data may arrive in the ack cycle itself or any later cycle, but never before ack.
  assign rd_ack       = (state == S_RD_WAIT) && !ack_seen && sdram_ack;
  assign rd_hit       = (state == S_RD_WAIT) && sdram_data_r_en && (ack_seen || sdram_ack);
  assign mismatch     = rd_hit && (sdram_data_r != pattern);
  assign finish       = word_done && (state == S_RD_WAIT) && last_word;

  always_comb begin
    pattern = SEED_W;
    case (mode_q)
      2'd1:    pattern = SEED_W + DATA_W'(idx);
      2'd2:    pattern = DATA_W'(word_addr);
      2'd3:    pattern = idx[0] ? ~SEED_W : SEED_W;
      default: pattern = SEED_W;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= S_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_pass = 1'b0;
    word_done  = 1'b0;
    abort      = 1'b0;
    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) begin
          if (AUTO_START) begin
            start_pass = 1'b1;
            state_next = S_WR_REQ;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (start) begin
          start_pass = 1'b1;
          state_next = S_WR_REQ;
        end
      end
      S_WR_REQ: state_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (sdram_ack) begin
          word_done  = 1'b1;
          state_next = last_word ? S_RD_REQ : S_WR_REQ;
        end else if (wait_expired) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      end
      S_RD_REQ: state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_hit) begin
          word_done  = 1'b1;
          state_next = last_word ? S_DONE : S_RD_REQ;
        end else if (!rd_ack && wait_expired) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start || (loop_en && pass)) begin
          start_pass = 1'b1;
          state_next = S_WR_REQ;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // Datapath: request outputs are registered and only change in the *_REQ states, so
  // address/data/direction stay stable for the whole time sdram_req is high.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      init_cnt       <= '0;
      wait_cnt       <= '0;
      idx            <= '0;
      mode_q         <= 2'd0;
      ack_seen       <= 1'b0;
      sdram_req      <= 1'b0;
      sdram_addr     <= '0;
      sdram_rh_wl    <= 1'b1;
      sdram_data_w   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_cnt       <= '0;
    end else begin
      if (state == S_INIT && init_cnt != INIT_LAST) init_cnt <= init_cnt + 1'b1;

      if (start_pass) begin
        idx            <= '0;
        mode_q         <= mode;
        err_cnt        <= '0;
        first_err_addr <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        busy           <= 1'b1;
      end

      if (state == S_WR_REQ || state == S_RD_REQ) begin
        sdram_req   <= 1'b1;
        sdram_addr  <= word_addr;
        sdram_rh_wl <= (state == S_RD_REQ);
        if (state == S_WR_REQ) sdram_data_w <= pattern;
        wait_cnt    <= '0;
        ack_seen    <= 1'b0;
      end

      if (state == S_WR_WAIT || state == S_RD_WAIT) begin
        if ((state == S_WR_WAIT && sdram_ack) || rd_ack) begin
          sdram_req <= 1'b0;
          ack_seen  <= 1'b1;
          wait_cnt  <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end

      if (word_done) idx <= last_word ? '0 : idx + 1'b1;

      if (mismatch) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'h0000) first_err_addr <= sdram_addr;
      end

      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_cnt == 16'h0000) && !mismatch;
        if ((err_cnt == 16'h0000) && !mismatch) pass_cnt <= pass_cnt + 8'd1;
      end

      if (abort) begin
        sdram_req <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        pass      <= 1'b0;
        timeout   <= 1'b1;
      end
    end
  end

  always_comb begin
    if (done && pass) led = 8'h55;
    else if (done)    led = 8'hAA;
    else              led = {busy, 3'b000, pass_cnt[3:0]};
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with a behavioural sdram_ctrl model
// (2-cycle ack, read data 3 cycles after ack or in the ack cycle, fault knobs).
`timescale 1ns/1ps
module tb_sdram_pattern_tester;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        start;
  logic [1:0]  mode;
  logic        loop_en;
  logic        sdram_req;
  logic        sdram_ack;
  logic [23:0] sdram_addr;
  logic        sdram_rh_wl;
  logic [15:0] sdram_data_w;
  logic [15:0] sdram_data_r;
  logic        sdram_data_r_en;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [23:0] first_err_addr;
  logic [7:0]  pass_cnt;
  logic [7:0]  led;

  int total = 0;
  int bad   = 0;

  // model knobs, written only while the DUT is idle or before a pass starts
  bit        flip_en = 0;
  bit [7:0]  flip_addr = 0;
  bit        stall_en = 0;
  bit [7:0]  stall_addr = 0;
  bit        concurrent = 0;

  logic [15:0] mem [0:255];
  logic [1:0]  ack_cnt;
  logic [1:0]  rd_dly;
  logic [15:0] rd_val;
  logic [15:0] rd_word;
  logic        stalled;

  int wr_acks = 0, rd_acks = 0, rd_ens = 0, proto_err = 0;
  logic        prev_req = 0, prev_ack = 0, prev_rh = 0;
  logic [23:0] prev_addr = 0;
  logic [15:0] prev_dw = 0;

  always #5 clk = ~clk;

  sdram_pattern_tester #(
    .DATA_W(16), .ADDR_W(24), .INIT_WAIT(20), .START_ADDR(0), .WORD_COUNT(8),
    .SEED('hF055), .TIMEOUT(15), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .mode(mode), .loop_en(loop_en),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w), .sdram_data_r(sdram_data_r),
    .sdram_data_r_en(sdram_data_r_en), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .pass_cnt(pass_cnt), .led(led)
  );

  assign rd_word = mem[sdram_addr[7:0]] ^ {15'd0, (flip_en && sdram_addr[7:0] == flip_addr)};
  assign stalled = stall_en && !sdram_rh_wl && (sdram_addr[7:0] == stall_addr);

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sdram_ack       <= 1'b0;
      sdram_data_r_en <= 1'b0;
      sdram_data_r    <= '0;
      ack_cnt         <= '0;
      rd_dly          <= '0;
      rd_val          <= '0;
    end else begin
      sdram_ack       <= 1'b0;
      sdram_data_r_en <= 1'b0;
      if (sdram_req && !sdram_ack && !stalled) begin
        if (ack_cnt == 2'd1) begin
          sdram_ack <= 1'b1;
          ack_cnt   <= '0;
          if (!sdram_rh_wl) mem[sdram_addr[7:0]] <= sdram_data_w;
          else if (concurrent) begin
            sdram_data_r_en <= 1'b1;
            sdram_data_r    <= rd_word;
          end else begin
            rd_dly <= 2'd3;
            rd_val <= rd_word;
          end
        end else begin
          ack_cnt <= ack_cnt + 2'd1;
        end
      end else begin
        ack_cnt <= '0;
      end
      if (rd_dly != 2'd0) begin
        rd_dly <= rd_dly - 2'd1;
        if (rd_dly == 2'd1) begin
          sdram_data_r_en <= 1'b1;
          sdram_data_r    <= rd_val;
        end
      end
    end
  end

  // handshake monitor: no req right after an accepted ack, request fields stable while pending
  always @(posedge clk) begin
    if (prev_req && prev_ack && sdram_req) proto_err++;
    if (prev_req && !prev_ack && sdram_req &&
        (sdram_addr != prev_addr || sdram_rh_wl != prev_rh || sdram_data_w != prev_dw))
      proto_err++;
    if (sdram_req && sdram_ack && !sdram_rh_wl) wr_acks++;
    if (sdram_req && sdram_ack && sdram_rh_wl) rd_acks++;
    if (sdram_data_r_en) rd_ens++;
    prev_req  = sdram_req;
    prev_ack  = sdram_ack;
    prev_rh   = sdram_rh_wl;
    prev_addr = sdram_addr;
    prev_dw   = sdram_data_w;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 0;
    for (int n = 0; n < max_cycles; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0; start = 1'b0; mode = 2'd0; loop_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk); #1;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req got=%0d want=0", sdram_req); end
    total++; if (sdram_rh_wl !== 1'b1) begin bad++; $display("[TB] FAIL rst_rh_wl got=%0d want=1", sdram_rh_wl); end
    total++; if ({busy, done, pass, timeout} !== 4'b0000) begin bad++; $display("[TB] FAIL rst_flags got=%b want=0000", {busy, done, pass, timeout}); end
    total++; if ({err_cnt, pass_cnt, led} !== 32'h0) begin bad++; $display("[TB] FAIL rst_counts got=%h want=0", {err_cnt, pass_cnt, led}); end
  endtask

  task automatic test_auto_start();
    bit ok;
    @(negedge clk); reset_l = 1'b1;
    repeat (19) @(posedge clk); #1;
    total++; if ({busy, sdram_req} !== 2'b00) begin bad++; $display("[TB] FAIL init_quiet got=%b want=00", {busy, sdram_req}); end
    @(posedge clk); #1;
    total++; if ({busy, sdram_req} !== 2'b10) begin bad++; $display("[TB] FAIL auto_busy got=%b want=10", {busy, sdram_req}); end
    @(posedge clk); #1;
    total++; if ({sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w} !== {2'b10, 24'd0, 16'hF055})
      begin bad++; $display("[TB] FAIL first_req got=%b/%b/%h/%h want=1/0/0/f055", sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w); end
    wait_done(400, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL pass1_done got=%0d want=1", ok); end
    total++; if (wr_acks !== 8 || rd_acks !== 8) begin bad++; $display("[TB] FAIL pass1_acks got=%0d/%0d want=8/8", wr_acks, rd_acks); end
    total++; if (mem[0] !== 16'hF055 || mem[7] !== 16'hF055) begin bad++; $display("[TB] FAIL pass1_mem got=%h/%h want=f055/f055", mem[0], mem[7]); end
    total++; if ({pass, timeout, err_cnt} !== {2'b10, 16'd0}) begin bad++; $display("[TB] FAIL pass1_result got=%b%b/%0d want=10/0", pass, timeout, err_cnt); end
    total++; if (pass_cnt !== 8'd1 || led !== 8'h55) begin bad++; $display("[TB] FAIL pass1_led got=%0d/%h want=1/55", pass_cnt, led); end
  endtask

  task automatic test_mismatch();
    bit ok;
    mode = 2'd1; flip_en = 1; flip_addr = 8'd5;
    pulse_start();
    mode = 2'd2;
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("[TB] FAIL mm_start got=%b want=10", {busy, done}); end
    wait_done(400, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL mm_done got=%0d want=1", ok); end
    total++; if (mem[3] !== 16'hF058 || mem[7] !== 16'hF05C) begin bad++; $display("[TB] FAIL mm_pattern got=%h/%h want=f058/f05c", mem[3], mem[7]); end
    total++; if (err_cnt !== 16'd1 || first_err_addr !== 24'd5) begin bad++; $display("[TB] FAIL mm_err got=%0d@%0d want=1@5", err_cnt, first_err_addr); end
    total++; if ({pass, led, pass_cnt} !== {1'b0, 8'hAA, 8'd1}) begin bad++; $display("[TB] FAIL mm_led got=%0d/%h/%0d want=0/aa/1", pass, led, pass_cnt); end
    flip_en = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt, w0;
    mode = 2'd0; stall_en = 1; stall_addr = 8'd2;
    w0 = wr_acks;
    pulse_start();
    total++; if ({err_cnt, first_err_addr, led} !== {16'd0, 24'd0, 8'h81}) begin bad++; $display("[TB] FAIL to_clear got=%0d/%0d/%h want=0/0/81", err_cnt, first_err_addr, led); end
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (sdram_req && !sdram_rh_wl && sdram_addr == 24'd2) begin ok = 1; break; end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL to_req_seen got=%0d want=1", ok); end
    cnt = 0;
    while (sdram_req && cnt < 100) begin cnt++; @(posedge clk); #1; end
    total++; if (cnt !== 15) begin bad++; $display("[TB] FAIL to_req_len got=%0d want=15", cnt); end
    total++; if ({timeout, pass, done, busy} !== 4'b1010) begin bad++; $display("[TB] FAIL to_flags got=%b want=1010", {timeout, pass, done, busy}); end
    total++; if (led !== 8'hAA || pass_cnt !== 8'd1 || err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL to_led got=%h/%0d/%0d want=aa/1/0", led, pass_cnt, err_cnt); end
    total++; if (wr_acks - w0 !== 2) begin bad++; $display("[TB] FAIL to_writes got=%0d want=2", wr_acks - w0); end
    stall_en = 0;
  endtask

  task automatic test_loop();
    bit ok;
    mode = 2'd3; loop_en = 1'b1;
    pulse_start();
    for (int target = 2; target <= 4; target++) begin
      ok = 0;
      for (int n = 0; n < 300; n++) begin
        @(posedge clk); #1;
        if (pass_cnt == 8'(target)) begin ok = 1; break; end
      end
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL loop_cnt got=%0d want=%0d", pass_cnt, target); end
    end
    loop_en = 1'b0;
    repeat (150) @(posedge clk); #1;
    total++; if (pass_cnt !== 8'd4) begin bad++; $display("[TB] FAIL loop_stop got=%0d want=4", pass_cnt); end
    total++; if ({done, pass, busy, led} !== {3'b110, 8'h55}) begin bad++; $display("[TB] FAIL loop_final got=%b/%h want=110/55", {done, pass, busy}, led); end
    total++; if (mem[0] !== 16'hF055 || mem[1] !== 16'h0FAA || mem[7] !== 16'h0FAA) begin bad++; $display("[TB] FAIL loop_mem got=%h/%h/%h want=f055/0faa/0faa", mem[0], mem[1], mem[7]); end
  endtask

  task automatic test_async_reset();
    bit ok;
    mode = 2'd0;
    pulse_start();
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (sdram_req && sdram_rh_wl) begin ok = 1; break; end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL ar_read_seen got=%0d want=1", ok); end
    #2 reset_l = 1'b0;
    #1;
    total++; if ({sdram_req, sdram_rh_wl, busy, done, pass, timeout} !== 6'b010000) begin bad++; $display("[TB] FAIL ar_flags got=%b want=010000", {sdram_req, sdram_rh_wl, busy, done, pass, timeout}); end
    total++; if ({err_cnt, first_err_addr, pass_cnt, led, sdram_addr, sdram_data_w} !== '0) begin bad++; $display("[TB] FAIL ar_values got=%h/%h/%h/%h want=0", err_cnt, pass_cnt, led, sdram_addr); end
    @(negedge clk); reset_l = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(posedge clk); #1;
    total++; if ({busy, sdram_req} !== 2'b00) begin bad++; $display("[TB] FAIL ar_start_ignored got=%b want=00", {busy, sdram_req}); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ar_auto got=%0d want=1", busy); end
    wait_done(400, ok);
    total++; if ({ok, pass, pass_cnt, led} !== {2'b11, 8'd1, 8'h55}) begin bad++; $display("[TB] FAIL ar_pass got=%0d%0d/%0d/%h want=11/1/55", ok, pass, pass_cnt, led); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w0, r0, e0;
    mode = 2'd1; concurrent = 1; flip_en = 1; flip_addr = 8'd3;
    w0 = wr_acks; r0 = rd_acks; e0 = rd_ens;
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(400, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done got=%0d want=1", ok); end
    total++; if (err_cnt !== 16'd1 || first_err_addr !== 24'd3) begin bad++; $display("[TB] FAIL b2b_err got=%0d@%0d want=1@3", err_cnt, first_err_addr); end
    total++; if (rd_acks - r0 !== 8 || rd_ens - e0 !== 8) begin bad++; $display("[TB] FAIL b2b_reads got=%0d/%0d want=8/8", rd_acks - r0, rd_ens - e0); end
    repeat (60) @(posedge clk); #1;
    total++; if (wr_acks - w0 !== 8 || {done, busy} !== 2'b10) begin bad++; $display("[TB] FAIL b2b_no_extra got=%0d/%b want=8/10", wr_acks - w0, {done, busy}); end
    total++; if ({pass, pass_cnt, led} !== {1'b0, 8'd1, 8'hAA}) begin bad++; $display("[TB] FAIL b2b_led got=%0d/%0d/%h want=0/1/aa", pass, pass_cnt, led); end
    concurrent = 0; flip_en = 0;
  endtask

  task automatic test_handshake();
    total++; if (proto_err !== 0) begin bad++; $display("[TB] FAIL handshake got=%0d want=0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_mismatch();
    test_timeout();
    test_loop();
    test_async_reset();
    test_back_to_back();
    test_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
